// File: rtl/ivl_uvm_odd_parity_gen.sv
// Odd-parity tagging FIFO: each accepted payload is stored as {parity, payload} and replayed in order.
// Defining IVL_UVM_ODD_PARITY_GEN_ERR_INJ_EN adds inject_err / err_inj_count for deliberate even-parity words.
module ivl_uvm_odd_parity_gen #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_data,
    output logic [15:0]      word_count
`ifdef IVL_UVM_ODD_PARITY_GEN_ERR_INJ_EN
    ,
    input  logic             inject_err,
    output logic [15:0]      err_inj_count
`endif
);

    // Handshake: a word moves on a port only in a cycle where valid && ready at the rising edge;
    // ready/valid come from registered state only, so neither depends combinationally on the other side.

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            push;
    logic            pop;
    logic            parity_bit;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

`ifdef IVL_UVM_ODD_PARITY_GEN_ERR_INJ_EN
    assign parity_bit = (~^in_data) ^ inject_err;
`else
    assign parity_bit = ~^in_data;
`endif

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
        state_next = ST_PARTIAL;
        if (count_next == '0) begin
            state_next = ST_EMPTY;
        end else if (count_next == DEPTH_CNT) begin
            state_next = ST_FULL;
        end
    end

    // Storage is not reset; out_data is meaningless while out_valid is low.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr] <= {parity_bit, in_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= ST_EMPTY;
            word_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                word_count <= word_count + 16'd1;
            end
            count <= count_next;
            state <= state_next;
        end
    end

`ifdef IVL_UVM_ODD_PARITY_GEN_ERR_INJ_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_inj_count <= '0;
        end else if (push && inject_err) begin
            err_inj_count <= err_inj_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ivl_uvm_odd_parity_gen.sv
// Bench for ivl_uvm_odd_parity_gen: parity table, directed corner sequences and a random run
// scored against a queue model of the FIFO.
module tb_ivl_uvm_odd_parity_gen;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_data;
    logic [15:0] word_count;
`ifdef IVL_UVM_ODD_PARITY_GEN_ERR_INJ_EN
    logic        inject_err;
    logic [15:0] err_inj_count;
`endif

    ivl_uvm_odd_parity_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count)
`ifdef IVL_UVM_ODD_PARITY_GEN_ERR_INJ_EN
        ,
        .inject_err    (inject_err),
        .err_inj_count (err_inj_count)
`endif
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int parity_fires = 0;

    // scoreboard
    logic [4:0]  exp_q[$];
    int unsigned model_wc;

    typedef struct {
        logic [3:0] din;
        logic [4:0] dout;
    } vec_t;
    vec_t vecs[16];

    // odd-parity checker on every delivered word
    always @(negedge clock) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 && (^out_data) !== 1'b1)
            parity_fires++;
    end

    function automatic logic [4:0] model_word(input logic [3:0] d);
        int ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(d[i]);
        return {1'((ones % 2) == 0), d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // one clock of traffic, with handshake decisions taken from the model
    task automatic cycle(input logic iv, input logic [3:0] d, input logic ordy);
        bit push_ok;
        bit pop_ok;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        push_ok = iv && (exp_q.size() < DEPTH);
        pop_ok  = ordy && (exp_q.size() > 0);
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
        step;
        if (pop_ok) begin
            void'(exp_q.pop_front());
            model_wc++;
        end
        if (push_ok) exp_q.push_back(model_word(d));
        check("word_count", 32'(word_count), model_wc & 32'hFFFF);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic reset_cycle(input logic iv, input logic [3:0] d, input logic ordy);
        reset     = 1'b1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        step;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        model_wc = 0;
    endtask

    initial begin
        vecs[0]  = '{4'h0, 5'b10000}; vecs[1]  = '{4'h1, 5'b00001};
        vecs[2]  = '{4'h2, 5'b00010}; vecs[3]  = '{4'h3, 5'b10011};
        vecs[4]  = '{4'h4, 5'b00100}; vecs[5]  = '{4'h5, 5'b10101};
        vecs[6]  = '{4'h6, 5'b10110}; vecs[7]  = '{4'h7, 5'b00111};
        vecs[8]  = '{4'h8, 5'b01000}; vecs[9]  = '{4'h9, 5'b11001};
        vecs[10] = '{4'hA, 5'b11010}; vecs[11] = '{4'hB, 5'b01011};
        vecs[12] = '{4'hC, 5'b11100}; vecs[13] = '{4'hD, 5'b01101};
        vecs[14] = '{4'hE, 5'b01110}; vecs[15] = '{4'hF, 5'b11111};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef IVL_UVM_ODD_PARITY_GEN_ERR_INJ_EN
        inject_err = 1'b0;
`endif
        step;
        step;
        reset = 1'b0;
        exp_q.delete();
        model_wc = 0;

        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_word_count", 32'(word_count), 32'd0);

        // three words in, three out, in order
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0011, 1'b0);
        cycle(1'b1, 4'b0111, 1'b0);
        check("seq_data0", 32'(out_data), 32'b10000);
        cycle(1'b0, 4'h0, 1'b1);
        check("seq_data1", 32'(out_data), 32'b10011);
        cycle(1'b0, 4'h0, 1'b1);
        check("seq_data2", 32'(out_data), 32'b00111);
        cycle(1'b0, 4'h0, 1'b1);
        check("seq_word_count", 32'(word_count), 32'd3);

        // parity table over every payload
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, vecs[i].din, 1'b0);
            check("table_valid", 32'(out_valid), 32'd1);
            check("table_data", 32'(out_data), 32'(vecs[i].dout));
            cycle(1'b0, 4'h0, 1'b1);
        end

        // full FIFO refuses a push even when popped in the same cycle
        reset_cycle(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 4'hA, 1'b1);
        check("after_full_pop_in_ready", 32'(in_ready), 32'd1);
        repeat (DEPTH) cycle(1'b0, 4'h0, 1'b1);
        check("drained_out_valid", 32'(out_valid), 32'd0);

        // latency into empty FIFO, then steady push+pop at occupancy 2
        reset_cycle(1'b0, 4'h0, 1'b0);
        check("pre_push_out_valid", 32'(out_valid), 32'd0);
        cycle(1'b1, 4'h5, 1'b0);
        check("post_push_out_valid", 32'(out_valid), 32'd1);
        cycle(1'b1, 4'h6, 1'b0);
        repeat (20) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b1);
        cycle(1'b0, 4'h0, 1'b1);
        check("occ2_one_left", 32'(out_valid), 32'd1);
        cycle(1'b0, 4'h0, 1'b1);
        check("occ2_empty", 32'(out_valid), 32'd0);

        // reset mid-transfer discards buffered words
        reset_cycle(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 9), 1'b0);
        reset_cycle(1'b1, 4'hF, 1'b1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_word_count", 32'(word_count), 32'd0);
        repeat (3) cycle(1'b0, 4'h0, 1'b1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0)
                reset_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else
                cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 1)));
        end
        repeat (DEPTH + 1) cycle(1'b0, 4'h0, 1'b1);

`ifdef IVL_UVM_ODD_PARITY_GEN_ERR_INJ_EN
        reset_cycle(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'b1;
            in_data    = 4'b0001;
            inject_err = (i == 1);
            step;
        end
        in_valid   = 1'b0;
        inject_err = 1'b0;
        check("err_inj_count", 32'(err_inj_count), 32'd1);
        check("inj_word0", 32'(out_data), 32'b00001);
        out_ready = 1'b1;
        step;
        check("inj_word1", 32'(out_data), 32'b10001);
        step;
        check("inj_word2", 32'(out_data), 32'b00001);
        step;
        out_ready = 1'b0;
        step;
        check("parity_checker_fires", 32'(parity_fires), 32'd1);
`else
        check("parity_checker_fires", 32'(parity_fires), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
